tri_raster_engine: RTL and testbench

- Parametrised triangle rasterizer: takes three screen-space vertices and a 16-bit colour, then fills the triangle into the SRAM framebuffer through the GPU-SRAM write port.
- Scans only the screen-clipped bounding box, one pixel per clock. Edge functions are updated incrementally with adders; the only multiplies are in setup.
- Start/busy/done handshake lets a command sequencer queue triangles. Framebuffer writes stall while video is active.

---
 rtl/gpu_pkg.sv | 32 +++
 rtl/tri_edge_eval.sv | 62 ++++++
 rtl/tri_raster_engine.sv | 267 ++++++++++++++++++++++++++
 tb/tb_tri_raster_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the GPU drawing blocks:
//   - state_t     : rasterizer FSM states
//   - edge_width  : signed edge-accumulator width for a given coordinate width
//   - DEF_SCREEN_W / DEF_SCREEN_H : default framebuffer geometry
//   - COLOR_WHITE / COLOR_BLACK   : 16-bit colour constants
// No ports (package).
// -----------------------------------------------------------------------------
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_BB,
        SETUP_E,
        SCAN,
        DONE
    } state_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 400;

    localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
    localparam logic [15:0] COLOR_BLACK = 16'h0000;

    // Differences of (coord_w+1)-bit signed operands, multiplied and
    // subtracted, need 2*coord_w+3 bits; one more bit of headroom on top.
    function automatic int edge_width(input int coord_w);
        return 2 * coord_w + 4;
    endfunction

endpackage

// File: rtl/tri_edge_eval.sv
// -----------------------------------------------------------------------------
// tri_edge_eval
// One incrementally evaluated triangle edge function. Holds the running value
// for the current pixel, the value at the start of the current row and the
// per-pixel / per-row increments.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_init into accumulator and row-start register,
//                    latch both increments
//   i_init         : edge value at (min_x, min_y)
//   i_inc_x        : added when stepping one pixel right
//   i_inc_row      : added to the row-start value when wrapping to next row
//   i_step_x       : step one pixel right
//   i_step_row     : wrap to the start of the next row
//   o_value        : edge value at the current pixel
// With no load/step asserted the accumulator holds.
// -----------------------------------------------------------------------------
module tri_edge_eval
    import gpu_pkg::*;
#(
    parameter int EDGE_W = edge_width(11)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_load,
    input  logic signed [EDGE_W-1:0] i_init,
    input  logic signed [EDGE_W-1:0] i_inc_x,
    input  logic signed [EDGE_W-1:0] i_inc_row,
    input  logic                     i_step_x,
    input  logic                     i_step_row,
    output logic signed [EDGE_W-1:0] o_value
);

    logic signed [EDGE_W-1:0] r_acc;
    logic signed [EDGE_W-1:0] r_row;
    logic signed [EDGE_W-1:0] r_inc_x;
    logic signed [EDGE_W-1:0] r_inc_row;
    logic signed [EDGE_W-1:0] w_row_next;

    assign w_row_next = r_row + r_inc_row;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_row     <= '0;
            r_inc_x   <= '0;
            r_inc_row <= '0;
        end else if (i_load) begin
            r_acc     <= i_init;
            r_row     <= i_init;
            r_inc_x   <= i_inc_x;
            r_inc_row <= i_inc_row;
        end else if (i_step_row) begin
            r_acc <= w_row_next;
            r_row <= w_row_next;
        end else if (i_step_x) begin
            r_acc <= r_acc + r_inc_x;
        end
    end

    assign o_value = r_acc;

endmodule

// File: rtl/tri_raster_engine.sv
// -----------------------------------------------------------------------------
// tri_raster_engine
// Fills a flat-coloured triangle into the SRAM framebuffer, scanning the
// screen-clipped bounding box row-major at one pixel per clock.
//   I_CLK, I_RST_N      : clock, asynchronous active-low reset
//   I_VIDEO_ON          : display owns SRAM; scan and pending write hold
//   I_START             : start request, sampled only in IDLE
//   I_AX..I_CY, I_COLOR : vertices and colour, latched on accepted start
//   O_BUSY, O_DONE      : busy from accepted start through DONE; DONE pulse
//   O_GPU_ADDR/DATA/WRITE : framebuffer write port (write accepted when
//                         O_GPU_WRITE=1 and I_VIDEO_ON=0)
//   O_GPU_READ          : always 0
// Optional build macro TRI_RASTER_STATS_EN adds O_PIX_COUNT, the number of
// accepted writes for the current/last triangle.
// -----------------------------------------------------------------------------
module tri_raster_engine
    import gpu_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COORD_W  = 11,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic               I_VIDEO_ON,
    input  logic               I_START,
    input  logic [COORD_W-1:0] I_AX,
    input  logic [COORD_W-1:0] I_AY,
    input  logic [COORD_W-1:0] I_BX,
    input  logic [COORD_W-1:0] I_BY,
    input  logic [COORD_W-1:0] I_CX,
    input  logic [COORD_W-1:0] I_CY,
    input  logic [DATA_W-1:0]  I_COLOR,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [DATA_W-1:0]  O_GPU_DATA,
    output logic               O_GPU_WRITE,
    output logic               O_GPU_READ
`ifdef TRI_RASTER_STATS_EN
    ,
    output logic [ADDR_W-1:0]  O_PIX_COUNT
`endif
);

    localparam int EDGE_W = edge_width(COORD_W);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(SCREEN_H - 1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
    localparam logic [ADDR_W-1:0]  ROW_PITCH = ADDR_W'(SCREEN_W);

    state_t r_state;
    state_t w_state_next;

    logic [COORD_W-1:0] r_vx [3];
    logic [COORD_W-1:0] r_vy [3];
    logic [DATA_W-1:0]  r_color;
    logic [COORD_W-1:0] r_min_x, r_max_x, r_min_y, r_max_y;
    logic [COORD_W-1:0] r_x, r_y;
    logic [ADDR_W-1:0]  r_row_base;
    logic [ADDR_W-1:0]  r_gpu_addr;
    logic [DATA_W-1:0]  r_gpu_data;
    logic               r_gpu_write;
    logic               r_issued_all;   // last pixel of the box has been issued

    logic [COORD_W-1:0] w_raw_min_x, w_raw_max_x, w_raw_min_y, w_raw_max_y;
    logic signed [EDGE_W-1:0] w_dx      [3];
    logic signed [EDGE_W-1:0] w_dy      [3];
    logic signed [EDGE_W-1:0] w_e_init  [3];
    logic signed [EDGE_W-1:0] w_e_inc_x [3];
    logic signed [EDGE_W-1:0] w_e_val   [3];
    logic signed [EDGE_W-1:0] w_area;
    logic [2:0] w_ge0, w_le0;
    logic       w_inside, w_advance, w_row_end, w_last;
    logic       w_load, w_step_x, w_step_row, w_start_ok;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Unsigned coordinate -> (COORD_W+1)-bit signed -> sign-extended to EDGE_W.
    function automatic logic signed [EDGE_W-1:0] sext(input logic [COORD_W-1:0] v);
        logic signed [COORD_W:0] s;
        s = {1'b0, v};
        return EDGE_W'(s);
    endfunction

    assign w_raw_min_x = min3(r_vx[0], r_vx[1], r_vx[2]);
    assign w_raw_max_x = max3(r_vx[0], r_vx[1], r_vx[2]);
    assign w_raw_min_y = min3(r_vy[0], r_vy[1], r_vy[2]);
    assign w_raw_max_y = max3(r_vy[0], r_vy[1], r_vy[2]);

    assign w_start_ok = (r_state == IDLE) && I_START;
    assign w_load     = (r_state == SETUP_E);
    assign w_row_end  = (r_x == r_max_x);
    assign w_last     = w_row_end && (r_y == r_max_y);
    // Video ownership freezes the whole scan, not only a pending write.
    assign w_advance  = (r_state == SCAN) && !I_VIDEO_ON && !r_issued_all;
    assign w_step_x   = w_advance && !w_row_end;
    assign w_step_row = w_advance && w_row_end && !w_last;

    // Edge gi runs from vertex (gi+1)%3 to (gi+2)%3: E0 b->c, E1 c->a, E2 a->b.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            localparam int I0 = (gi + 1) % 3;
            localparam int I1 = (gi + 2) % 3;

            assign w_dx[gi] = sext(r_vx[I1]) - sext(r_vx[I0]);
            assign w_dy[gi] = sext(r_vy[I1]) - sext(r_vy[I0]);
            assign w_e_init[gi] = w_dx[gi] * (sext(r_min_y) - sext(r_vy[I0]))
                                - w_dy[gi] * (sext(r_min_x) - sext(r_vx[I0]));
            assign w_e_inc_x[gi] = -w_dy[gi];

            tri_edge_eval #(
                .EDGE_W(EDGE_W)
            ) u_edge (
                .i_clk      (I_CLK),
                .i_rst_n    (I_RST_N),
                .i_load     (w_load),
                .i_init     (w_e_init[gi]),
                .i_inc_x    (w_e_inc_x[gi]),
                .i_inc_row  (w_dx[gi]),
                .i_step_x   (w_step_x),
                .i_step_row (w_step_row),
                .o_value    (w_e_val[gi])
            );

            assign w_ge0[gi] = !w_e_val[gi][EDGE_W-1];
            assign w_le0[gi] = w_e_val[gi][EDGE_W-1] || (w_e_val[gi] == '0);
        end
    endgenerate

    // Twice the signed area: E0 evaluated at vertex a.
    assign w_area = w_dx[0] * (sext(r_vy[0]) - sext(r_vy[1]))
                  - w_dy[0] * (sext(r_vx[0]) - sext(r_vx[1]));

    assign w_inside = (&w_ge0) || (&w_le0);

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (I_START) w_state_next = SETUP_BB;
            SETUP_BB: w_state_next = (w_raw_min_x > X_LAST || w_raw_min_y > Y_LAST)
                                     ? DONE : SETUP_E;
            SETUP_E:  w_state_next = (w_area == '0) ? DONE : SCAN;
            // One drain cycle after the last pixel lets its write be accepted.
            SCAN:     if (!I_VIDEO_ON && r_issued_all) w_state_next = DONE;
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
            r_color      <= '0;
            r_min_x      <= '0;
            r_max_x      <= '0;
            r_min_y      <= '0;
            r_max_y      <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_row_base   <= '0;
            r_gpu_addr   <= '0;
            r_gpu_data   <= DATA_W'(COLOR_BLACK);
            r_gpu_write  <= 1'b0;
            r_issued_all <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (I_START) begin
                        r_vx[0] <= I_AX;  r_vy[0] <= I_AY;
                        r_vx[1] <= I_BX;  r_vy[1] <= I_BY;
                        r_vx[2] <= I_CX;  r_vy[2] <= I_CY;
                        r_color <= I_COLOR;
                    end
                end
                SETUP_BB: begin
                    // The min side cannot exceed the screen here: that case
                    // leaves for DONE, so only the max side needs clamping.
                    r_min_x <= w_raw_min_x;
                    r_min_y <= w_raw_min_y;
                    r_max_x <= (w_raw_max_x > X_LAST) ? X_LAST : w_raw_max_x;
                    r_max_y <= (w_raw_max_y > Y_LAST) ? Y_LAST : w_raw_max_y;
                end
                SETUP_E: begin
                    r_x          <= r_min_x;
                    r_y          <= r_min_y;
                    r_row_base   <= ADDR_W'(r_min_y) * ROW_PITCH;
                    r_issued_all <= 1'b0;
                end
                SCAN: begin
                    if (!I_VIDEO_ON) begin
                        if (r_issued_all) begin
                            r_gpu_write <= 1'b0;
                        end else begin
                            r_gpu_write <= w_inside;
                            if (w_inside) begin
                                r_gpu_addr <= r_row_base + ADDR_W'(r_x);
                                r_gpu_data <= r_color;
                            end
                            if (w_last) begin
                                r_issued_all <= 1'b1;
                            end else if (w_row_end) begin
                                r_x        <= r_min_x;
                                r_y        <= r_y + COORD_ONE;
                                r_row_base <= r_row_base + ROW_PITCH;
                            end else begin
                                r_x <= r_x + COORD_ONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRI_RASTER_STATS_EN
    logic [ADDR_W-1:0] r_pix_count;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_pix_count <= '0;
        end else if (w_start_ok) begin
            r_pix_count <= '0;
        end else if (r_gpu_write && !I_VIDEO_ON) begin
            r_pix_count <= r_pix_count + ADDR_W'(1);
        end
    end

    assign O_PIX_COUNT = r_pix_count;
`endif

    assign O_BUSY      = (r_state != IDLE);
    assign O_DONE      = (r_state == DONE);
    assign O_GPU_ADDR  = r_gpu_addr;
    assign O_GPU_DATA  = r_gpu_data;
    assign O_GPU_WRITE = r_gpu_write;
    assign O_GPU_READ  = 1'b0;

endmodule

// File: tb/tb_tri_raster_engine.sv
// -----------------------------------------------------------------------------
// tb_tri_raster_engine
// Scoreboard bench for tri_raster_engine: stimulus pushes the hand-derived
// pixel addresses of each triangle into a queue, a negedge monitor pops and
// compares on every accepted framebuffer write. Build with
// TRI_RASTER_STATS_EN defined to also check O_PIX_COUNT.
// -----------------------------------------------------------------------------
module tb_tri_raster_engine;
    import gpu_pkg::*;

    localparam int COORD_W = 11;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int SW      = 640;

    logic               I_CLK      = 1'b0;
    logic               I_RST_N    = 1'b0;
    logic               I_VIDEO_ON = 1'b0;
    logic               I_START    = 1'b0;
    logic [COORD_W-1:0] I_AX = '0, I_AY = '0, I_BX = '0, I_BY = '0, I_CX = '0, I_CY = '0;
    logic [DATA_W-1:0]  I_COLOR = '0;
    logic               O_BUSY, O_DONE, O_GPU_WRITE, O_GPU_READ;
    logic [ADDR_W-1:0]  O_GPU_ADDR;
    logic [DATA_W-1:0]  O_GPU_DATA;
`ifdef TRI_RASTER_STATS_EN
    logic [ADDR_W-1:0]  O_PIX_COUNT;
`endif

    tri_raster_engine #(
        .SCREEN_W(SW), .SCREEN_H(400), .COORD_W(COORD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .I_CLK       (I_CLK),
        .I_RST_N     (I_RST_N),
        .I_VIDEO_ON  (I_VIDEO_ON),
        .I_START     (I_START),
        .I_AX        (I_AX),
        .I_AY        (I_AY),
        .I_BX        (I_BX),
        .I_BY        (I_BY),
        .I_CX        (I_CX),
        .I_CY        (I_CY),
        .I_COLOR     (I_COLOR),
        .O_BUSY      (O_BUSY),
        .O_DONE      (O_DONE),
        .O_GPU_ADDR  (O_GPU_ADDR),
        .O_GPU_DATA  (O_GPU_DATA),
        .O_GPU_WRITE (O_GPU_WRITE),
        .O_GPU_READ  (O_GPU_READ)
`ifdef TRI_RASTER_STATS_EN
        ,
        .O_PIX_COUNT (O_PIX_COUNT)
`endif
    );

    always #5 I_CLK = ~I_CLK;

    int                vectors     = 0;
    int                miscompares = 0;
    int                writes_seen = 0;
    bit                mon_en      = 1'b0;
    logic [ADDR_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_color   = '0;

    // Monitor: every accepted write is matched against the scoreboard head.
    always @(negedge I_CLK) begin
        if (mon_en && I_RST_N && O_GPU_WRITE && !I_VIDEO_ON) begin
            logic [ADDR_W-1:0] exp_a;
            writes_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write",
                         O_GPU_ADDR, O_GPU_DATA);
            end else begin
                exp_a = exp_q.pop_front();
                if (O_GPU_ADDR !== exp_a || O_GPU_DATA !== exp_color) begin
                    miscompares++;
                    $display("FAIL write_%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                             writes_seen, O_GPU_ADDR, O_GPU_DATA, exp_a, exp_color);
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic prep(input logic [DATA_W-1:0] col);
        exp_q.delete();
        writes_seen = 0;
        exp_color   = col;
    endtask

    // Right isosceles triangle with corner (10,10), legs of length 10:
    // row y covers x = 10 .. 30-y.
    task automatic push_tri1();
        for (int y = 10; y <= 20; y++)
            for (int x = 10; x <= 30 - y; x++)
                exp_q.push_back(ADDR_W'(y * SW + x));
    endtask

    // Hypotenuse x = 700-14y; clipped at x=639 for rows 0..4, row 5 only x=630.
    task automatic push_clip();
        for (int y = 0; y <= 4; y++)
            for (int x = 630; x <= 639; x++)
                exp_q.push_back(ADDR_W'(y * SW + x));
        exp_q.push_back(ADDR_W'(5 * SW + 630));
    endtask

    task automatic start_tri(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, input logic [DATA_W-1:0] col);
        @(posedge I_CLK); #1;
        I_AX = COORD_W'(ax); I_AY = COORD_W'(ay);
        I_BX = COORD_W'(bx); I_BY = COORD_W'(by);
        I_CX = COORD_W'(cx); I_CY = COORD_W'(cy);
        I_COLOR = col;
        I_START = 1'b1;
        @(posedge I_CLK); #1;
        I_START = 1'b0;
    endtask

    // Waits for DONE (counting negedges since the accepted start when the
    // caller comes straight from start_tri), presents a start during the DONE
    // cycle that must be ignored, then checks write totals.
    task automatic wait_done(input string name, input int exp_writes, input int exp_cycles);
        int cycles = 0;
        bit seen   = 1'b0;
        while (!seen && cycles < 3000) begin
            @(negedge I_CLK);
            cycles++;
            if (O_DONE) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_done: got no DONE in %0d cycles, required a DONE pulse", name, cycles);
        end else begin
            check({name, "_busy_in_done"}, O_BUSY, 1);
            if (exp_cycles >= 0) check({name, "_done_latency"}, cycles, exp_cycles);
            I_START = 1'b1;
            @(posedge I_CLK); #1;
            I_START = 1'b0;
            @(negedge I_CLK);
            check({name, "_done_one_cycle"}, O_DONE, 0);
            check({name, "_busy_after_done"}, O_BUSY, 0);
        end
        check({name, "_write_count"}, writes_seen, exp_writes);
        check({name, "_missing_writes"}, exp_q.size(), 0);
        $display("tri %s: writes=%0d cycles_to_done=%0d", name, writes_seen, cycles);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [ADDR_W+DATA_W:0] snap;

        // Reset state
        repeat (3) @(posedge I_CLK);
        @(negedge I_CLK);
        check("rst_busy",  O_BUSY, 0);
        check("rst_done",  O_DONE, 0);
        check("rst_write", O_GPU_WRITE, 0);
        check("rst_read",  O_GPU_READ, 0);
        check("rst_addr",  O_GPU_ADDR, 0);
        check("rst_data",  O_GPU_DATA, 0);
        @(posedge I_CLK); #1;
        I_RST_N = 1'b1;
        mon_en  = 1'b1;

        // Counter-clockwise triangle, with first-write latency
        prep(16'h0F0F);
        push_tri1();
        start_tri(10, 10, 20, 10, 10, 20, 16'h0F0F);
        lat = 0;
        while (lat < 20) begin
            @(negedge I_CLK);
            lat++;
            if (lat == 1) check("busy_after_start", O_BUSY, 1);
            if (O_GPU_WRITE) break;
        end
        check("first_write_latency", lat, 4);
        wait_done("ccw", 66, -1);

        // Reversed winding: same pixel set and order
        prep(16'hF0F0);
        push_tri1();
        start_tri(10, 10, 10, 20, 20, 10, 16'hF0F0);
        wait_done("cw", 66, -1);

        // Degenerate (collinear): no writes, DONE three cycles after start
        prep(16'h1234);
        start_tri(0, 0, 5, 5, 10, 10, 16'h1234);
        wait_done("collinear", 0, 3);

        // Entirely right of the screen: rejected at bounding-box setup
        prep(16'h4321);
        start_tri(700, 10, 710, 10, 700, 20, 16'h4321);
        wait_done("offscreen", 0, 2);

        // Right-edge clipping
        prep(COLOR_WHITE);
        push_clip();
        start_tri(630, 0, 700, 0, 630, 5, COLOR_WHITE);
        wait_done("clip", 51, -1);

        // Video ownership for 20 cycles mid-scan
        prep(16'hA5A5);
        push_tri1();
        start_tri(10, 10, 20, 10, 10, 20, 16'hA5A5);
        repeat (20) @(posedge I_CLK);
        #1 I_VIDEO_ON = 1'b1;
        @(negedge I_CLK);
        snap = {O_GPU_WRITE, O_GPU_ADDR, O_GPU_DATA};
        for (int i = 1; i < 20; i++) begin
            @(negedge I_CLK);
            check($sformatf("video_hold_%0d", i), {O_GPU_WRITE, O_GPU_ADDR, O_GPU_DATA}, snap);
        end
        @(posedge I_CLK); #1;
        I_VIDEO_ON = 1'b0;
        wait_done("video_stall", 66, -1);

        // Reset mid-scan, then a fresh run with a start pulsed while busy
        prep(16'h0F0F);
        push_tri1();
        start_tri(10, 10, 20, 10, 10, 20, 16'h0F0F);
        repeat (30) @(posedge I_CLK);
        #1;
        mon_en  = 1'b0;
        I_RST_N = 1'b0;
        @(negedge I_CLK);
        check("midrst_busy",  O_BUSY, 0);
        check("midrst_done",  O_DONE, 0);
        check("midrst_write", O_GPU_WRITE, 0);
        check("midrst_addr",  O_GPU_ADDR, 0);
        check("midrst_data",  O_GPU_DATA, 0);
`ifdef TRI_RASTER_STATS_EN
        check("midrst_pix_count", O_PIX_COUNT, 0);
`endif
        @(posedge I_CLK); #1;
        I_RST_N = 1'b1;
        prep(16'h7E7E);
        push_tri1();
        mon_en = 1'b1;
        start_tri(10, 10, 20, 10, 10, 20, 16'h7E7E);
        repeat (5) @(posedge I_CLK);
        #1;
        I_AX = 0;  I_AY = 0;  I_BX = 5;  I_BY = 0;  I_CX = 0;  I_CY = 5;
        I_COLOR = 16'hDEAD;
        I_START = 1'b1;
        @(posedge I_CLK); #1;
        I_START = 1'b0;
        wait_done("restart_ignore", 66, -1);
`ifdef TRI_RASTER_STATS_EN
        check("pix_count", O_PIX_COUNT, 66);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
